// File: rtl/ram_port_arbiter_pkg.sv
// Shared memory-interface definitions for the MD RAM port arbiter.
//   MD_ADDR_WIDTH / MD_DATA_WIDTH / MD_RD_LATENCY : default geometry and RAM read latency
//   req_id_e                                      : requester-id encoding carried in read tags
package ram_port_arbiter_pkg;

  localparam int MD_ADDR_WIDTH = 12;
  localparam int MD_DATA_WIDTH = 32;
  localparam int MD_RD_LATENCY = 2;

  typedef enum logic {
    REQ_ID_0 = 1'b0,
    REQ_ID_1 = 1'b1
  } req_id_e;

endpackage

// File: rtl/rd_tag_pipe.sv
// Read-tag delay line: a DEPTH-stage shift register carrying a valid bit and
// the requester id of each read, so the response can be steered to the right
// requester when the RAM data arrives.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset (clears all stages)
//   vld_i, id_i    : tag entering the pipe this cycle
//   vld_o, id_o    : tag leaving the last stage
module rd_tag_pipe
  import ram_port_arbiter_pkg::*;
#(
  parameter int DEPTH = MD_RD_LATENCY
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vld_i,
  input  logic id_i,
  output logic vld_o,
  output logic id_o
);

  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] id_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      id_q  <= '0;
    end else begin
      vld_q[0] <= vld_i;
      id_q[0]  <= id_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        id_q[i]  <= id_q[i-1];
      end
    end
  end

  assign vld_o = vld_q[DEPTH-1];
  assign id_o  = id_q[DEPTH-1];

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port RAM with a
// fixed read latency.
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   reqN_valid/ready/wren/addr/data : command handshake for requester N (ready is combinational)
//   rspN_valid/rspN_data            : one-cycle read-data pulse for requester N, data held between pulses
//   ram_address/ram_data/ram_wren   : registered RAM command
//   ram_rd_data                     : RAM read data, valid RD_LATENCY cycles after the address
// Timing of a read transferred at edge E:
//   E              : command registered onto the RAM pins, read tag captured in the issue stage
//   E+1..E+RD_LAT  : tag moves through rd_tag_pipe while the RAM works
//   E+1+RD_LAT     : ram_rd_data captured into rspN_data, rspN_valid pulses
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = MD_ADDR_WIDTH,
  parameter int DATA_WIDTH = MD_DATA_WIDTH,
  parameter int RD_LATENCY = MD_RD_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_wren,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_wren,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_data,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_data,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  // Grant and selected command
  logic                  gnt0;
  logic                  gnt1;
  logic                  xfer;
  logic                  sel_wren;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  // Registered state
  logic                  ptr_q,         ptr_d;
  logic [ADDR_WIDTH-1:0] ram_address_q, ram_address_d;
  logic [DATA_WIDTH-1:0] ram_data_q,    ram_data_d;
  logic                  ram_wren_q,    ram_wren_d;
  logic                  rd_vld_q,      rd_vld_d;
  logic                  rd_id_q,       rd_id_d;
  logic                  rsp0_valid_q,  rsp0_valid_d;
  logic                  rsp1_valid_q,  rsp1_valid_d;
  logic [DATA_WIDTH-1:0] rsp0_data_q,   rsp0_data_d;
  logic [DATA_WIDTH-1:0] rsp1_data_q,   rsp1_data_d;

  // Tag leaving the delay line, aligned with ram_rd_data
  logic                  tag_vld;
  logic                  tag_id;

  // Round-robin grant. ptr_q names the requester that wins a tie. Gating with
  // rst_n keeps both readys low for the whole reset assertion.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (req0_valid && (!req1_valid || (ptr_q == REQ_ID_0))) begin
        gnt0 = 1'b1;
      end else if (req1_valid) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign xfer     = gnt0 | gnt1;
  assign sel_wren = gnt1 ? req1_wren : req0_wren;
  assign sel_addr = gnt1 ? req1_addr : req0_addr;
  assign sel_data = gnt1 ? req1_data : req0_data;

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    ptr_d         = ptr_q;
    ram_address_d = ram_address_q;
    ram_data_d    = ram_data_q;
    ram_wren_d    = 1'b0;
    rd_vld_d      = 1'b0;
    rd_id_d       = rd_id_q;
    if (xfer) begin
      // The loser of this grant gets priority next time: granting 0 points at 1.
      ptr_d         = gnt0;
      ram_address_d = sel_addr;
      ram_data_d    = sel_data;
      ram_wren_d    = sel_wren;
      rd_vld_d      = ~sel_wren;
      rd_id_d       = gnt1 ? REQ_ID_1 : REQ_ID_0;
    end

    rsp0_valid_d = tag_vld && (tag_id == REQ_ID_0);
    rsp1_valid_d = tag_vld && (tag_id == REQ_ID_1);
    rsp0_data_d  = rsp0_valid_d ? ram_rd_data : rsp0_data_q;
    rsp1_data_d  = rsp1_valid_d ? ram_rd_data : rsp1_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q         <= REQ_ID_0;
      ram_address_q <= '0;
      ram_data_q    <= '0;
      ram_wren_q    <= 1'b0;
      rd_vld_q      <= 1'b0;
      rd_id_q       <= REQ_ID_0;
      rsp0_valid_q  <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp0_data_q   <= '0;
      rsp1_data_q   <= '0;
    end else begin
      ptr_q         <= ptr_d;
      ram_address_q <= ram_address_d;
      ram_data_q    <= ram_data_d;
      ram_wren_q    <= ram_wren_d;
      rd_vld_q      <= rd_vld_d;
      rd_id_q       <= rd_id_d;
      rsp0_valid_q  <= rsp0_valid_d;
      rsp1_valid_q  <= rsp1_valid_d;
      rsp0_data_q   <= rsp0_data_d;
      rsp1_data_q   <= rsp1_data_d;
    end
  end

  // The issue-stage tag (rd_vld_q/rd_id_q) is presented with the RAM address;
  // it then needs exactly RD_LATENCY more cycles to line up with ram_rd_data.
  rd_tag_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_rd_tag_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .vld_i (rd_vld_q),
    .id_i  (rd_id_q),
    .vld_o (tag_vld),
    .id_o  (tag_id)
  );

  assign ram_address = ram_address_q;
  assign ram_data    = ram_data_q;
  assign ram_wren    = ram_wren_q;
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp0_data   = rsp0_data_q;
  assign rsp1_data   = rsp1_data_q;

endmodule
